flow_slot_fifo: RTL and testbench

Single-clock FIFO that holds request-queue slot IDs for one transmit flow in the CCI-P transmitter. One instance per flow: the push side enqueues slot IDs as requests land in the request queue, and the transmit scheduler pops them in batches. It reports live occupancy so the scheduler can check batch readiness, and it flags dropped pushes for packet-drop statistics.

---
 rtl/flow_slot_fifo.sv | 89 ++++++++
 tb/tb_flow_slot_fifo.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/flow_slot_fifo.sv
// rtl/flow_slot_fifo.sv - per-flow slot-ID FIFO with occupancy and overflow reporting
// Define FLOW_SLOT_FIFO_OVF_STICKY_EN for a sticky overflow error; default is a one-cycle pulse.
module flow_slot_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int LOG_DEPTH  = 3
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  clear,
    input  logic                  push_en,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop_enable,
    output logic                  pop_valid,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic [LOG_DEPTH-1:0]  pop_dw,
    output logic                  error
);
    localparam int DEPTH = 1 << LOG_DEPTH;
    localparam logic [LOG_DEPTH-1:0] FULL_COUNT = '1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [LOG_DEPTH-1:0]  wr_ptr;
    logic [LOG_DEPTH-1:0]  rd_ptr;
    logic [LOG_DEPTH-1:0]  count;
    logic                  full;
    logic                  empty;
    logic                  do_push;
    logic                  do_pop;
    logic                  drop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_pop  = pop_enable && !empty;
    // A pop in the same cycle frees a slot, so a push while full still lands.
    assign do_push = push_en && (!full || do_pop);
    assign drop    = push_en && full && !do_pop;
    assign pop_dw  = count;

    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            pop_valid <= 1'b0;
            pop_data  <= '0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            pop_valid <= 1'b0;
        end else begin
            pop_valid <= do_pop;
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                pop_data <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            error <= 1'b0;
        end else if (clear) begin
            error <= 1'b0;
        end else begin
`ifdef FLOW_SLOT_FIFO_OVF_STICKY_EN
            if (drop) begin
                error <= 1'b1;
            end
`else
            error <= drop;
`endif
        end
    end
endmodule

// File: tb/tb_flow_slot_fifo.sv
// tb/tb_flow_slot_fifo.sv - directed self-checking bench for flow_slot_fifo
module tb_flow_slot_fifo;
    logic       clk;
    logic       resetn;
    logic       clear;
    logic       push_en;
    logic [7:0] push_data;
    logic       pop_enable;
    logic       pop_valid;
    logic [7:0] pop_data;
    logic [2:0] pop_dw;
    logic       error;

    int err_cnt;
    int chk_cnt;

`ifdef FLOW_SLOT_FIFO_OVF_STICKY_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    flow_slot_fifo #(.DATA_WIDTH(8), .LOG_DEPTH(3)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (clear),
        .push_en   (push_en),
        .push_data (push_data),
        .pop_enable(pop_enable),
        .pop_valid (pop_valid),
        .pop_data  (pop_data),
        .pop_dw    (pop_dw),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic push, input logic [7:0] data, input logic pop);
        push_en    = push;
        push_data  = data;
        pop_enable = pop;
    endtask

    initial begin
        logic [7:0] next_in;
        logic [7:0] next_out;
        err_cnt    = 0;
        chk_cnt    = 0;
        resetn     = 1'b0;
        clear      = 1'b0;
        drive(1'b0, 8'h00, 1'b0);

        tick(); tick();
        check("rst_valid", pop_valid, 0);
        check("rst_data", pop_data, 0);
        check("rst_dw", pop_dw, 0);
        check("rst_err", error, 0);
        resetn = 1'b1;
        tick();

        // pop on empty
        drive(1'b0, 8'h00, 1'b1);
        tick();
        check("empty_pop_valid", pop_valid, 0);
        check("empty_pop_err", error, 0);
        check("empty_pop_dw", pop_dw, 0);

        // order and latency
        drive(1'b1, 8'h11, 1'b0); tick();
        drive(1'b1, 8'h22, 1'b0); tick();
        drive(1'b1, 8'h33, 1'b0); tick();
        check("order_dw3", pop_dw, 3);
        drive(1'b0, 8'h00, 1'b1); tick();
        check("order_v0", pop_valid, 1); check("order_d0", pop_data, 8'h11);
        tick();
        check("order_v1", pop_valid, 1); check("order_d1", pop_data, 8'h22);
        drive(1'b0, 8'h00, 1'b1); tick();
        check("order_v2", pop_valid, 1); check("order_d2", pop_data, 8'h33);
        drive(1'b0, 8'h00, 1'b0); tick();
        check("order_done_valid", pop_valid, 0);
        check("order_done_dw", pop_dw, 0);

        // fill to capacity
        for (int i = 1; i <= 7; i++) begin
            drive(1'b1, 8'(i), 1'b0);
            tick();
        end
        check("full_dw", pop_dw, 7);
        drive(1'b1, 8'hAA, 1'b0); tick();
        check("ovf_dw", pop_dw, 7);
        check("ovf_err", error, 1);
        drive(1'b0, 8'h00, 1'b0); tick();
        check("ovf_err_after", error, STICKY);

        // push+pop while full
        drive(1'b1, 8'h55, 1'b1); tick();
        check("fullpp_valid", pop_valid, 1);
        check("fullpp_data", pop_data, 8'h01);
        check("fullpp_dw", pop_dw, 7);
        check("fullpp_err", error, STICKY);
        for (int i = 2; i <= 8; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            tick();
            check("drain_valid", pop_valid, 1);
            check("drain_data", pop_data, (i == 8) ? 8'h55 : 8'(i));
        end
        drive(1'b0, 8'h00, 1'b0); tick();
        check("drain_dw", pop_dw, 0);
        check("drain_valid_end", pop_valid, 0);
        clear = 1'b1; tick(); clear = 1'b0;
        check("clear_err", error, 0);

        // push+pop on empty: no bypass
        drive(1'b1, 8'h66, 1'b1); tick();
        check("emptypp_valid", pop_valid, 0);
        check("emptypp_dw", pop_dw, 1);
        drive(1'b0, 8'h00, 1'b1); tick();
        check("emptypp_pop_valid", pop_valid, 1);
        check("emptypp_pop_data", pop_data, 8'h66);

        // wrap-around at occupancy 2
        next_in  = 8'h40;
        next_out = 8'h40;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, next_in, 1'b0);
            next_in++;
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, next_in, 1'b1);
            next_in++;
            tick();
            check("wrap_valid", pop_valid, 1);
            check("wrap_data", pop_data, next_out);
            check("wrap_dw", pop_dw, 2);
            next_out++;
        end

        // clear alongside a push with 4 entries
        drive(1'b1, 8'h90, 1'b0); tick();
        drive(1'b1, 8'h91, 1'b0); tick();
        check("pre_clear_dw", pop_dw, 4);
        clear = 1'b1;
        drive(1'b1, 8'h92, 1'b0); tick();
        clear = 1'b0;
        drive(1'b0, 8'h00, 1'b0);
        check("clear_dw", pop_dw, 0);
        check("clear_error", error, 0);
        check("clear_valid", pop_valid, 0);

        // asynchronous reset mid-stream with 4 entries
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'hC0 + 8'(i), 1'b0);
            tick();
        end
        drive(1'b0, 8'h00, 1'b1); tick();
        check("prereset_data", pop_data, 8'hC0);
        drive(1'b0, 8'h00, 1'b0);
        #2;
        resetn = 1'b0;
        #1;
        check("async_rst_valid", pop_valid, 0);
        check("async_rst_data", pop_data, 0);
        check("async_rst_dw", pop_dw, 0);
        check("async_rst_err", error, 0);
        tick();
        resetn = 1'b1;
        drive(1'b1, 8'h77, 1'b0); tick();
        check("post_rst_dw", pop_dw, 1);
        drive(1'b0, 8'h00, 1'b1); tick();
        check("post_rst_data", pop_data, 8'h77);
        drive(1'b0, 8'h00, 1'b0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
